// File: rtl/cr_clint_tmr.sv
// Machine-timer / software / external interrupt unit: holds msip and mtimecmp
// behind a single-cycle register port and drives registered pendings to the IU.
module cr_clint_tmr #(
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic [63:0] sysio_clint_mtime,
  input  logic        sysio_clint_me_int,
  input  logic        clint_req,
  input  logic        clint_write,
  input  logic [15:0] clint_addr,
  input  logic [31:0] clint_wdata,
  output logic        clint_cmplt,
  output logic        clint_err,
  output logic [31:0] clint_rdata,
  output logic        clint_iu_mtip,
  output logic        clint_iu_msip,
  output logic        clint_iu_meip
);

  localparam logic [15:0] ADDR_MSIP   = 16'h0000;
  localparam logic [15:0] ADDR_CMP_LO = 16'h4000;
  localparam logic [15:0] ADDR_CMP_HI = 16'h4004;
  localparam logic [15:0] ADDR_MT_LO  = 16'hBFF8;
  localparam logic [15:0] ADDR_MT_HI  = 16'hBFFC;

  logic [63:0] mtimecmp;
  logic        msip_q;
  logic        mtip_q;
  logic        meip_q;
  logic [31:0] snap_hi;
  logic        snap_vld;
  logic        cmplt_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        hit_msip;
  logic        hit_cmp_lo;
  logic        hit_cmp_hi;
  logic        hit_mt_lo;
  logic        hit_mt_hi;
  logic        acc_err;
  logic [31:0] rd_val;

  // Misaligned, unmapped and mtime-write accesses are answered with an error.
  always_comb begin
    hit_msip   = (clint_addr == ADDR_MSIP);
    hit_cmp_lo = (clint_addr == ADDR_CMP_LO);
    hit_cmp_hi = (clint_addr == ADDR_CMP_HI);
    hit_mt_lo  = (clint_addr == ADDR_MT_LO);
    hit_mt_hi  = (clint_addr == ADDR_MT_HI);
    acc_err    = (clint_addr[1:0] != 2'b00)
               || !(hit_msip || hit_cmp_lo || hit_cmp_hi || hit_mt_lo || hit_mt_hi)
               || (clint_write && (hit_mt_lo || hit_mt_hi));
  end

  always_comb begin
    rd_val = 32'h0;
    if (hit_msip)   rd_val = {31'h0, msip_q};
    if (hit_cmp_lo) rd_val = mtimecmp[31:0];
    if (hit_cmp_hi) rd_val = mtimecmp[63:32];
    if (hit_mt_lo)  rd_val = sysio_clint_mtime[31:0];
    if (hit_mt_hi)  rd_val = snap_vld ? snap_hi : sysio_clint_mtime[63:32];
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      mtimecmp <= CMP_RST;
      msip_q   <= 1'b0;
      mtip_q   <= 1'b0;
      meip_q   <= 1'b0;
      snap_hi  <= 32'h0;
      snap_vld <= 1'b0;
      cmplt_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      mtip_q  <= (sysio_clint_mtime >= mtimecmp);
      meip_q  <= sysio_clint_me_int;
      cmplt_q <= clint_req;
      err_q   <= clint_req && acc_err;
      rdata_q <= (clint_req && !acc_err && !clint_write) ? rd_val : 32'h0;
      if (clint_req && !acc_err) begin
        if (clint_write && hit_msip)   msip_q          <= clint_wdata[0];
        if (clint_write && hit_cmp_lo) mtimecmp[31:0]  <= clint_wdata;
        if (clint_write && hit_cmp_hi) mtimecmp[63:32] <= clint_wdata;
        // A low-half read latches the high half so a LO/HI pair is coherent.
        if (!clint_write && hit_mt_lo) begin
          snap_hi  <= sysio_clint_mtime[63:32];
          snap_vld <= 1'b1;
        end else begin
          snap_vld <= 1'b0;
        end
      end
    end
  end

  assign clint_cmplt   = cmplt_q;
  assign clint_err     = err_q;
  assign clint_rdata   = rdata_q;
  assign clint_iu_mtip = mtip_q;
  assign clint_iu_msip = msip_q;
  assign clint_iu_meip = meip_q;

endmodule

// File: doc/cr_clint_tmr.md
# cr_clint_tmr

Machine-timer/software-interrupt unit directly downstream of the system I/O stage. It consumes the sampled 64-bit system count (`sysio_clint_mtime`) and the sampled external-interrupt level (`sysio_clint_me_int`). It holds the `msip` and `mtimecmp` registers behind a single-cycle register port and drives registered timer, software and external interrupt pendings to the IU.

## Interface
Parameters:
- `CMP_RST`, 64'hFFFF_FFFF_FFFF_FFFF, reset value of `mtimecmp` (keeps `mtip` low out of reset)

Ports:
- `forever_cpuclk`  in  1  only clock, rising edge
- `cpurst_b`  in  1  reset: synchronous, active-low (sampled on `forever_cpuclk`)
- `sysio_clint_mtime`  in  64  current system time
- `sysio_clint_me_int`  in  1  external interrupt level
- `clint_req`  in  1  access request, valid for one cycle per access
- `clint_write`  in  1  1 = write, 0 = read; qualified by `clint_req`
- `clint_addr`  in  16  byte address
- `clint_wdata`  in  32  write data
- `clint_cmplt`  out  1  response strobe, one cycle
- `clint_err`  out  1  error response, valid with `clint_cmplt`
- `clint_rdata`  out  32  read data, valid with `clint_cmplt`
- `clint_iu_mtip`  out  1  timer interrupt pending
- `clint_iu_msip`  out  1  software interrupt pending
- `clint_iu_meip`  out  1  external interrupt pending

## Operation
Register map (word accesses only):
- 0x0000 `MSIP`: bit0 R/W; bits 31:1 read 0, writes ignored.
- 0x4000 `MTIMECMP_LO`: R/W.
- 0x4004 `MTIMECMP_HI`: R/W.
- 0xBFF8 `MTIME_LO`: RO.
- 0xBFFC `MTIME_HI`: RO.

Error responses:
- Raised for an unmapped address, `clint_addr[1:0]` != 0, or a write to `MTIME_*`.
- Response is `clint_err`=1 and `clint_rdata`=0. No register changes.

Coherent mtime read:
- A read of `MTIME_LO` returns `mtime[31:0]`, captures `mtime[63:32]` into `snap_hi`, and sets `snap_vld`.
- A read of `MTIME_HI` with `snap_vld`=1 returns `snap_hi` and clears `snap_vld`.
- A read of `MTIME_HI` with `snap_vld`=0 returns live `mtime[63:32]`.
- Any other accepted access clears `snap_vld`.

Interrupts:
- `mtip_q <= (mtime >= mtimecmp)`, unsigned 64-bit compare, evaluated every cycle. Equality asserts.
- `msip` is the `MSIP` bit0 register.
- `meip_q <= sysio_clint_me_int`.
- All three outputs come directly from flops.

Writes:
- `MTIMECMP` halves are written independently, with no write lock.
- Software sequencing (hi=all-ones, lo, hi) is the programmer's responsibility. Transient `mtip` from intermediate values is permitted.

## Timing
- Request sampled at the edge ending cycle N. Writes update the register at that edge.
- `clint_cmplt`, `clint_err` and `clint_rdata` are registered and valid for exactly cycle N+1. They are 0 in all other cycles.
- Back-to-back requests are allowed in every cycle. Throughput is 1 access/cycle with no stall.
- Reads return the register value from before any write in the same cycle. Only one access is possible per cycle, so no same-cycle hazard exists.
- `mtimecmp` written in cycle N: `mtip` reflects the new compare in cycle N+2.
- `mtime` change at cycle M: `mtip` follows in cycle M+1.
- `MSIP` written in cycle N: `clint_iu_msip` updates in cycle N+1.
- `meip` lags `sysio_clint_me_int` by one cycle.
- Reset values (`cpurst_b`=0 at an edge):
  - `mtimecmp`=`CMP_RST`, `msip`=0, `snap_vld`=0, `snap_hi`=0.
  - All outputs 0, including `mtip`, `msip`, `meip`, `cmplt`, `err` and `rdata`.
- Reset mid-operation: a request sampled on a reset edge is dropped, with no response and no write. A response due in the cycle after a reset edge is suppressed.
- Deassertion: the first request is accepted at the first edge with `cpurst_b`=1.

## Test plan
- Reset with `mtime`=0: all outputs 0, and `MTIMECMP_LO`/`MTIMECMP_HI` read back 0xFFFFFFFF. Each response has `cmplt` exactly one cycle after its `req`.
- `mtime`=0x0000_0001_0000_0010. Write `MTIMECMP_HI`=0x1 (cycle N), then `MTIMECMP_LO`=0x10 (cycle N+1).
  - `mtip`=0 for `mtimecmp`=0x0000_0001_FFFF_FFFF from cycle N+2.
  - `mtip`=1 from cycle N+3 (equality asserts).
  - Write `LO`=0x11: `mtip`=0 two cycles later.
- `mtime` crosses 0x0000_0000_FFFF_FFFF → 0x1_0000_0000 between a `MTIME_LO` read and a `MTIME_HI` read.
  - Reads return 0xFFFFFFFF and 0x0 (snapshot).
  - An unpaired `MTIME_HI` read returns live 0x1.
- Errors: write to 0xBFF8, read of 0x4002, read of 0x1000. Each gives `cmplt`=1 and `err`=1 with `rdata`=0, and leaves `mtimecmp` and `msip` unchanged.
- `MSIP` write 0xFFFFFFFF: `msip`=1 next cycle and readback is 0x1. Write 0: `msip`=0. `sysio_clint_me_int` pulse of 3 cycles: `meip` pulse of 3 cycles, delayed 1.
- Back-to-back: 4 consecutive requests with `cpurst_b` asserted on the 3rd.
  - Responses 1–2 are correct.
  - The 3rd request has no response and its write is dropped.
  - The 4th, issued after deassertion, responds normally.
